// File: rtl/bnn_vote_accumulator.sv
// bnn_vote_accumulator
//   Collects the per-sample class votes from the layer-2 neurons of the BNN
//   core over a window of WINDOW accepted samples, then scans the per-class
//   counters to pick the winner. The winner is published with a one-cycle
//   out_valid pulse. The result fields hold their value until the next result.
//
//   Optional feature macro: BNN_VOTE_TIE_EN
//     defined   -> adds the out_tie port and the tie-tracking logic.
//     undefined -> no out_tie port and no tie logic.
//
// Ports
//   clk        in   1            rising-edge clock
//   reset      in   1            asynchronous, active-high reset
//   ena        in   1            global enable; low freezes all state
//   clear      in   1            synchronous abort/restart of the current window
//   in_valid   in   1            class_bits valid this cycle
//   class_bits in   NUM_CLASSES  bit c = vote for class c
//   busy       out  1            high while resolving/reporting; in_valid dropped
//   out_valid  out  1            one-cycle result pulse
//   out_class  out  IDX_W        winning class index (held)
//   out_count  out  CNT_W        vote count of the winning class (held)
//   out_tie    out  1            another class matched the winning count (held)
//
// Handshake: a sample is taken on a rising edge where ena & in_valid are high
//   and busy is low. There is no back-pressure. Input offered while busy is
//   high is discarded. out_valid is a pulse that has no ready.
module bnn_vote_accumulator #(
   parameter int NUM_CLASSES = 4,
   parameter int WINDOW      = 8,
   parameter int CNT_W       = $clog2(WINDOW + 1),
   parameter int IDX_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ena,
   input  logic                   clear,
   input  logic                   in_valid,
   input  logic [NUM_CLASSES-1:0] class_bits,
   output logic                   busy,
   output logic                   out_valid,
   output logic [IDX_W-1:0]       out_class,
`ifdef BNN_VOTE_TIE_EN
   output logic                   out_tie,
`endif
   output logic [CNT_W-1:0]       out_count
);

   typedef enum logic [1:0] {
      ST_ACCUM   = 2'd0,
      ST_RESOLVE = 2'd1,
      ST_REPORT  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(WINDOW - 1);
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_CLASSES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q [NUM_CLASSES];
   logic [CNT_W-1:0] cnt_d [NUM_CLASSES];
   logic [CNT_W-1:0] sample_q, sample_d;
   logic [IDX_W-1:0] scan_q, scan_d;
   logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
   logic [IDX_W-1:0] best_idx_q, best_idx_d;
   logic             out_valid_d;
   logic [IDX_W-1:0] out_class_d;
   logic [CNT_W-1:0] out_count_d;
`ifdef BNN_VOTE_TIE_EN
   logic             tie_q, tie_d;
   logic             out_tie_d;
`endif

   assign busy = (state_q != ST_ACCUM);

   // Next-state and datapath
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sample_d    = sample_q;
      scan_d      = scan_q;
      best_cnt_d  = best_cnt_q;
      best_idx_d  = best_idx_q;
      // out_valid is a pulse: it drops on the following clock even when ena is low.
      out_valid_d = 1'b0;
      out_class_d = out_class;
      out_count_d = out_count;
`ifdef BNN_VOTE_TIE_EN
      tie_d       = tie_q;
      out_tie_d   = out_tie;
`endif

      if (ena) begin
         case (state_q)
            ST_ACCUM: begin
               if (clear) begin
                  for (int c = 0; c < NUM_CLASSES; c++) cnt_d[c] = '0;
                  sample_d = '0;
               end else if (in_valid) begin
                  for (int c = 0; c < NUM_CLASSES; c++)
                     cnt_d[c] = cnt_q[c] + CNT_W'(class_bits[c]);
                  sample_d = sample_q + CNT_W'(1);
                  if (sample_q == LAST_SAMPLE) begin
                     state_d    = ST_RESOLVE;
                     scan_d     = '0;
                     best_cnt_d = '0;
                     best_idx_d = '0;
`ifdef BNN_VOTE_TIE_EN
                     tie_d      = 1'b0;
`endif
                  end
               end
            end

            ST_RESOLVE: begin
               if (clear) begin
                  for (int c = 0; c < NUM_CLASSES; c++) cnt_d[c] = '0;
                  sample_d = '0;
                  state_d  = ST_ACCUM;
               end else begin
                  // Strict compare: the lowest index among equal maxima keeps the win.
                  if (cnt_q[scan_q] > best_cnt_q) begin
                     best_cnt_d = cnt_q[scan_q];
                     best_idx_d = scan_q;
`ifdef BNN_VOTE_TIE_EN
                     tie_d      = 1'b0;
                  end else if ((cnt_q[scan_q] == best_cnt_q) && (best_cnt_q != '0) &&
                               (scan_q != '0)) begin
                     tie_d      = 1'b1;
`endif
                  end
                  if (scan_q == LAST_IDX) state_d = ST_REPORT;
                  else                    scan_d  = scan_q + IDX_W'(1);
               end
            end

            ST_REPORT: begin
               // Published even if clear is high this cycle.
               out_valid_d = 1'b1;
               out_class_d = best_idx_q;
               out_count_d = best_cnt_q;
`ifdef BNN_VOTE_TIE_EN
               out_tie_d   = tie_q;
`endif
               for (int c = 0; c < NUM_CLASSES; c++) cnt_d[c] = '0;
               sample_d = '0;
               state_d  = ST_ACCUM;
            end

            default: state_d = ST_ACCUM;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_ACCUM;
         for (int c = 0; c < NUM_CLASSES; c++) cnt_q[c] <= '0;
         sample_q   <= '0;
         scan_q     <= '0;
         best_cnt_q <= '0;
         best_idx_q <= '0;
         out_valid  <= 1'b0;
         out_class  <= '0;
         out_count  <= '0;
`ifdef BNN_VOTE_TIE_EN
         tie_q      <= 1'b0;
         out_tie    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         for (int c = 0; c < NUM_CLASSES; c++) cnt_q[c] <= cnt_d[c];
         sample_q   <= sample_d;
         scan_q     <= scan_d;
         best_cnt_q <= best_cnt_d;
         best_idx_q <= best_idx_d;
         out_valid  <= out_valid_d;
         out_class  <= out_class_d;
         out_count  <= out_count_d;
`ifdef BNN_VOTE_TIE_EN
         tie_q      <= tie_d;
         out_tie    <= out_tie_d;
`endif
      end
   end

endmodule

// File: tb/tb_bnn_vote_accumulator.sv
// Testbench for bnn_vote_accumulator (default parameters NUM_CLASSES=4, WINDOW=8).
// Expected results come from a per-class vote tally kept in the bench. The
// winner is the first class that holds the maximum tally. The tie flag is set
// when more than one class holds a non-zero maximum.
module tb_bnn_vote_accumulator;
   localparam int NUM_CLASSES = 4;
   localparam int WINDOW      = 8;
   localparam int CNT_W       = $clog2(WINDOW + 1);
   localparam int IDX_W       = 2;
   localparam int RES_W       = IDX_W + CNT_W;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   ena;
   logic                   clear;
   logic                   in_valid;
   logic [NUM_CLASSES-1:0] class_bits;
   logic                   busy;
   logic                   out_valid;
   logic [IDX_W-1:0]       out_class;
   logic [CNT_W-1:0]       out_count;
`ifdef BNN_VOTE_TIE_EN
   logic                   out_tie;
`endif

   int total = 0;
   int bad   = 0;
   int model_cnt [NUM_CLASSES];
   logic [RES_W-1:0] exp_q[$];
   logic             exp_tie_q[$];

   bnn_vote_accumulator #(.NUM_CLASSES(NUM_CLASSES), .WINDOW(WINDOW)) dut (
      .clk        (clk),
      .reset      (reset),
      .ena        (ena),
      .clear      (clear),
      .in_valid   (in_valid),
      .class_bits (class_bits),
      .busy       (busy),
      .out_valid  (out_valid),
      .out_class  (out_class),
`ifdef BNN_VOTE_TIE_EN
      .out_tie    (out_tie),
`endif
      .out_count  (out_count)
   );

   // clock / reset
   always #5 clk = ~clk;

   // One clock: return 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int c = 0; c < NUM_CLASSES; c++) model_cnt[c] = 0;
   endtask

   // Reference: tally maximum, first class holding it, tie if shared non-zero max.
   function automatic void model_result(output logic [IDX_W-1:0] c_o,
                                        output logic [CNT_W-1:0] k_o,
                                        output logic             t_o);
      int mx, first, nmax;
      mx = 0;
      for (int c = 0; c < NUM_CLASSES; c++) if (model_cnt[c] > mx) mx = model_cnt[c];
      first = -1;
      nmax  = 0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
         if (model_cnt[c] == mx) begin
            nmax++;
            if (first < 0) first = c;
         end
      end
      c_o = IDX_W'(first);
      k_o = CNT_W'(mx);
      t_o = (nmax > 1) && (mx > 0);
   endfunction

   // driver: one accepted sample, optionally preceded by ena-low cycles
   task automatic push_sample(input logic [NUM_CLASSES-1:0] bits, input int ena_gaps);
      class_bits = bits;
      in_valid   = 1'b1;
      for (int g = 0; g < ena_gaps; g++) begin
         ena = 1'b0;
         tick();
      end
      ena = 1'b1;
      tick();
      for (int c = 0; c < NUM_CLASSES; c++) if (bits[c]) model_cnt[c]++;
   endtask

   task automatic push_n(input logic [NUM_CLASSES-1:0] bits, input int n);
      for (int i = 0; i < n; i++) push_sample(bits, 0);
   endtask

   // Call right after the last sample of a window. ena is held low for
   // `gaps` cycles starting at wait iteration `gap_at`.
   task automatic expect_result(input string name, input int gap_at, input int gaps);
      logic [IDX_W-1:0] ec;
      logic [CNT_W-1:0] ek;
      logic             et;
      logic [RES_W-1:0] exp_r;
      int n, busy_n;
      model_result(ec, ek, et);
      exp_q.push_back({ec, ek});
      exp_tie_q.push_back(et);
      n = 0;
      busy_n = 0;
      while (!out_valid && n < 40) begin
         if (busy) busy_n++;
         ena = !(n >= gap_at && n < gap_at + gaps);
         tick();
         n++;
      end
      ena   = 1'b1;
      exp_r = exp_q.pop_front();
      et    = exp_tie_q.pop_front();
      total++;
      if (out_valid !== 1'b1) begin
         bad++;
         $display("FAIL %s timeout: out_valid=%b after %0d cycles, required 1", name, out_valid, n);
      end else begin
         total++;
         if (n !== NUM_CLASSES + 1 + gaps) begin
            bad++;
            $display("FAIL %s latency: got %0d required %0d", name, n, NUM_CLASSES + 1 + gaps);
         end
         total++;
         if ({out_class, out_count} !== exp_r) begin
            bad++;
            $display("FAIL %s result: class=%0d count=%0d required class=%0d count=%0d",
                     name, out_class, out_count, exp_r[RES_W-1:CNT_W], exp_r[CNT_W-1:0]);
         end
         total++;
         if (busy_n !== NUM_CLASSES + 1 + gaps || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s busy: cycles=%0d now=%b required cycles=%0d now=0",
                     name, busy_n, busy, NUM_CLASSES + 1 + gaps);
         end
`ifdef BNN_VOTE_TIE_EN
         total++;
         if (out_tie !== et) begin
            bad++;
            $display("FAIL %s tie: got %b required %b", name, out_tie, et);
         end
`endif
         in_valid = 1'b0;
         tick();
         total++;
         if (out_valid !== 1'b0 || {out_class, out_count} !== exp_r) begin
            bad++;
            $display("FAIL %s pulse/hold: out_valid=%b class=%0d count=%0d required 0 %0d %0d",
                     name, out_valid, out_class, out_count, exp_r[RES_W-1:CNT_W], exp_r[CNT_W-1:0]);
         end
      end
      model_clear();
   endtask

   task automatic check_outputs(input string name, input logic v, input logic b,
                                input logic [IDX_W-1:0] c, input logic [CNT_W-1:0] k);
      total++;
      if (out_valid !== v || busy !== b || out_class !== c || out_count !== k) begin
         bad++;
         $display("FAIL %s: valid=%b busy=%b class=%0d count=%0d required %b %b %0d %0d",
                  name, out_valid, busy, out_class, out_count, v, b, c, k);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; ena = 1'b0; clear = 1'b0; in_valid = 1'b0; class_bits = '0;
      model_clear();
      #12;
      check_outputs("reset_state", 1'b0, 1'b0, '0, '0);
`ifdef BNN_VOTE_TIE_EN
      total++;
      if (out_tie !== 1'b0) begin bad++; $display("FAIL reset_tie: got %b required 0", out_tie); end
`endif
      @(posedge clk); #1;
      reset = 1'b0; ena = 1'b1;
      tick();
   endtask

   task automatic test_single_class();
      push_n(4'b0100, WINDOW);
      in_valid = 1'b0;
      expect_result("single_class", 0, 0);
   endtask

   task automatic test_majority();
      push_n(4'b0001, 5);
      push_n(4'b1000, 3);
      in_valid = 1'b0;
      expect_result("majority", 0, 0);
   endtask

   task automatic test_tie();
      push_n(4'b0010, 4);
      push_n(4'b1000, 4);
      in_valid = 1'b0;
      expect_result("tie", 0, 0);
   endtask

   task automatic test_busy_drop();
      for (int i = 0; i < WINDOW; i++) push_sample(4'($urandom_range(0, 15)), 0);
      class_bits = 4'b1111;
      in_valid   = 1'b1;
      expect_result("busy_first", 0, 0);
      push_n(4'b0001, WINDOW);
      in_valid = 1'b0;
      expect_result("busy_second", 0, 0);
   endtask

   task automatic test_reset_and_clear();
      push_n(4'b1000, WINDOW);
      in_valid = 1'b0;
      expect_result("pre_reset", 0, 0);
      push_n(4'b1000, 3);
      #2 reset = 1'b1;
      #1 check_outputs("async_reset", 1'b0, 1'b0, '0, '0);
      tick();
      reset = 1'b0; in_valid = 1'b0;
      model_clear();
      tick();
      push_n(4'b0100, WINDOW);
      in_valid = 1'b0;
      expect_result("after_reset", 0, 0);
      // clear mid-window: leftover votes would end the next window early
      push_n(4'b1000, 3);
      in_valid = 1'b0;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check_outputs("clear_window", 1'b0, 1'b0, 2'd2, 4'd8);
      model_clear();
      push_n(4'b0010, WINDOW);
      in_valid = 1'b0;
      expect_result("after_clear", 0, 0);
      // clear during the scan aborts it
      push_n(4'b0001, WINDOW);
      in_valid = 1'b0;
      tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      begin
         int seen;
         seen = 0;
         for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            tick();
         end
         total++;
         if (seen != 0 || busy !== 1'b0 || out_class !== 2'd1 || out_count !== 4'd8) begin
            bad++;
            $display("FAIL clear_scan: pulses=%0d busy=%b class=%0d count=%0d required 0 0 1 8",
                     seen, busy, out_class, out_count);
         end
      end
      model_clear();
   endtask

   task automatic test_clear_in_report();
      logic [IDX_W-1:0] ec;
      logic [CNT_W-1:0] ek;
      logic             et;
      push_n(4'b0100, 6);
      push_n(4'b0001, 2);
      in_valid = 1'b0;
      model_result(ec, ek, et);
      repeat (NUM_CLASSES) tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check_outputs("clear_in_report", 1'b1, 1'b0, ec, ek);
      model_clear();
      tick();
      push_n(4'b1000, WINDOW);
      in_valid = 1'b0;
      expect_result("after_report_clear", 0, 0);
   endtask

   task automatic test_ena_gaps();
      for (int i = 0; i < WINDOW; i++) push_sample(4'b0010, $urandom_range(0, 2));
      in_valid = 1'b0;
      expect_result("ena_gaps", 1, 2);
      push_n(4'b0000, WINDOW);
      in_valid = 1'b0;
      expect_result("all_zero", 0, 0);
   endtask

   task automatic test_random();
      for (int w = 0; w < 8; w++) begin
         for (int i = 0; i < WINDOW; i++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            push_sample(4'($urandom_range(0, 15)), $urandom_range(0, 1));
         end
         in_valid = 1'b0;
         expect_result("random", $urandom_range(0, 3), $urandom_range(0, 2));
      end
   endtask

   initial begin
      test_reset();
      test_single_class();
      test_majority();
      test_tie();
      test_busy_drop();
      test_reset_and_clear();
      test_clear_in_report();
      test_ena_gaps();
      test_random();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard: %0d results left, required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
